jtframe_cen_bank: RTL

- Synthesizable, parametrised bank of CH fractional clock-enable generators, all running from one master clock.
- Each channel emits a one-cycle cen strobe at an average rate of clk·num/den, and optionally a half-period-offset cenb strobe.
- Provides a locked output that gates all strobes until a fixed settle delay has elapsed after reset.
- Replaces per-frequency divided-clock outputs in core top levels. Cores get clean enables on the single system clock instead of extra clocks.

---
 rtl/jtframe_cen_bank.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/jtframe_cen_bank.sv
// jtframe_cen_bank: bank of CH fractional clock-enable generators on one clock.
// Each channel strobes cen at an average rate of clk*num/den. The bank stays
// quiet until a fixed settle delay after reset has elapsed (locked).
// Optional feature macro JTFRAME_CEN_BANK_CENB_EN: when defined, a shadow
// accumulator per channel, preloaded with den/2, drives the half-phase cenb
// strobe. When undefined, no shadow logic is built and cenb is tied to 0.
module jtframe_cen_bank #(
   parameter int CH       = 4,
   parameter int W        = 10,
   parameter int NUM0     = 1,
   parameter int DEN0     = 2,
   parameter int LOCK_DLY = 16,
   localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [W-1:0]   cfg_num,
   input  logic [W-1:0]   cfg_den,
   output logic [CH-1:0]  cen,
   output logic [CH-1:0]  cenb,
   output logic           locked
);

   localparam logic [W-1:0] NUM0_W     = W'(NUM0);
   localparam logic [W-1:0] DEN0_W     = W'(DEN0);
   localparam logic [W-1:0] SACC0_W    = W'(DEN0 / 2);
   localparam logic [7:0]   LOCK_DLY_W = 8'(LOCK_DLY);

   logic [7:0]    lock_cnt_q, lock_cnt_d;
   logic          locked_q, locked_d;
   logic [W-1:0]  num_q [CH];
   logic [W-1:0]  num_d [CH];
   logic [W-1:0]  den_q [CH];
   logic [W-1:0]  den_d [CH];
   logic [W-1:0]  acc_q [CH];
   logic [W-1:0]  acc_d [CH];
   logic [W:0]    sum   [CH];
   logic [W:0]    diff  [CH];
   logic [CH-1:0] cen_q, cen_d;

   logic          wr_hit;
   logic [W-1:0]  wr_num;

`ifdef JTFRAME_CEN_BANK_CENB_EN
   logic [W-1:0]  sacc_q [CH];
   logic [W-1:0]  sacc_d [CH];
   logic [W:0]    ssum   [CH];
   logic [W:0]    sdiff  [CH];
   logic [CH-1:0] cenb_q, cenb_d;
`endif

   // Next-state: lock counter, config writes, and per-channel accumulation.
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      num_d      = num_q;
      den_d      = den_q;
      acc_d      = acc_q;
      cen_d      = '0;
      // den=0 and out-of-range channels are dropped; num is clamped to den
      wr_hit     = cfg_we && (int'(cfg_ch) < CH) && (cfg_den != '0);
      wr_num     = (cfg_num > cfg_den) ? cfg_den : cfg_num;
`ifdef JTFRAME_CEN_BANK_CENB_EN
      sacc_d     = sacc_q;
      cenb_d     = '0;
`endif

      if (!locked_q) begin
         lock_cnt_d = lock_cnt_q + 8'd1;
         if (lock_cnt_d == LOCK_DLY_W) locked_d = 1'b1;
      end

      for (int i = 0; i < CH; i++) begin
         sum[i]  = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
         diff[i] = sum[i] - {1'b0, den_q[i]};
`ifdef JTFRAME_CEN_BANK_CENB_EN
         ssum[i]  = {1'b0, sacc_q[i]} + {1'b0, num_q[i]};
         sdiff[i] = ssum[i] - {1'b0, den_q[i]};
`endif
         if (wr_hit && cfg_ch == CHW'(i)) begin
            // a freshly written channel skips one cycle so it restarts clean
            num_d[i] = wr_num;
            den_d[i] = cfg_den;
            acc_d[i] = '0;
`ifdef JTFRAME_CEN_BANK_CENB_EN
            sacc_d[i] = cfg_den >> 1;
`endif
         end else if (locked_q) begin
            if (sum[i] >= {1'b0, den_q[i]}) begin
               acc_d[i] = diff[i][W-1:0];
               cen_d[i] = 1'b1;
            end else begin
               acc_d[i] = sum[i][W-1:0];
            end
`ifdef JTFRAME_CEN_BANK_CENB_EN
            if (ssum[i] >= {1'b0, den_q[i]}) begin
               sacc_d[i] = sdiff[i][W-1:0];
               cenb_d[i] = 1'b1;
            end else begin
               sacc_d[i] = ssum[i][W-1:0];
            end
`endif
         end
      end
   end

   // State registers; reset has priority over any config write.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         cen_q      <= '0;
         for (int i = 0; i < CH; i++) begin
            num_q[i] <= NUM0_W;
            den_q[i] <= DEN0_W;
            acc_q[i] <= '0;
         end
      end else begin
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         cen_q      <= cen_d;
         num_q      <= num_d;
         den_q      <= den_d;
         acc_q      <= acc_d;
      end
   end

`ifdef JTFRAME_CEN_BANK_CENB_EN
   // Shadow accumulators for the half-phase strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         cenb_q <= '0;
         for (int i = 0; i < CH; i++) sacc_q[i] <= SACC0_W;
      end else begin
         cenb_q <= cenb_d;
         sacc_q <= sacc_d;
      end
   end

   assign cenb = cenb_q;
`else
   assign cenb = '0;
`endif

   assign cen    = cen_q;
   assign locked = locked_q;

endmodule
